// File: rtl/act_unit_arbiter.sv
`timescale 1ns/1ps
// act_unit_arbiter: round-robin, burst-locked sharing of one fixed-latency
// activation unit among NUM_REQ producers. Each issued beat carries its owner
// id down a tag pipe matched to ACT_LAT so results can be routed back.
// Optional per-requester accepted-beat counters: define ACT_ARB_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | no owner; grant on enable and any req_valid, searching up from ptr
// BURST  | gnt owns the datapath until its last beat handshakes
module act_unit_arbiter #(
   parameter  int N        = 16,
   parameter  int CHANNELS = 16,
   parameter  int NUM_REQ  = 4,
   parameter  int ACT_LAT  = 2,
   localparam int CW       = $clog2(CHANNELS),
   localparam int IW       = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_last,
   input  logic [NUM_REQ*N-1:0]  req_data,
   input  logic [NUM_REQ*CW-1:0] req_channel,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [N-1:0]          act_data_out,
   output logic [CW-1:0]         act_channel_out,
   output logic                  act_valid_out,
   input  logic [N-1:0]          act_data_in,
   input  logic [CW-1:0]         act_channel_in,
   input  logic                  act_valid_in,
   output logic [N-1:0]          rsp_data,
   output logic [CW-1:0]         rsp_channel,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic                  busy,
`ifdef ACT_ARB_PERF_CNT_EN
   input  logic                  perf_clr,
   output logic [NUM_REQ*32-1:0] perf_beats,
`endif
   output logic                  lat_err
);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t        state, state_nx;
   logic [IW-1:0] gnt, gnt_nx, ptr, ptr_nx, pick, ptr_inc;
   logic [IW:0]   idx;
   logic          found, hs;
   logic [IW-1:0] iss_id;
   logic [ACT_LAT-1:0] tag_v;
   logic [IW-1:0] tag_id [ACT_LAT];
   logic          tail_v;
   logic [IW-1:0] tail_id;

   assign hs      = (state == S_BURST) && req_valid[gnt];
   assign ptr_inc = (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
   assign tail_v  = tag_v[ACT_LAT-1];
   assign tail_id = tag_id[ACT_LAT-1];
   assign busy    = (state == S_BURST) || act_valid_out || (|tag_v);

   // first valid requester at or after ptr, wrapping modulo NUM_REQ
   always_comb begin
      pick  = ptr;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, ptr} + (IW+1)'(k);
         if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
         if (!found && req_valid[idx[IW-1:0]]) begin
            found = 1'b1;
            pick  = idx[IW-1:0];
         end
      end
   end

   // next state, grant and pointer; ready is driven only for the owner
   always_comb begin
      state_nx  = state;
      gnt_nx    = gnt;
      ptr_nx    = ptr;
      req_ready = '0;
      case (state)
         S_IDLE: begin
            if (enable && found) begin
               state_nx = S_BURST;
               gnt_nx   = pick;
            end
         end
         S_BURST: begin
            req_ready[gnt] = 1'b1;
            if (hs && req_last[gnt]) begin
               state_nx = S_IDLE;
               ptr_nx   = ptr_inc;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         gnt   <= '0;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         gnt   <= gnt_nx;
         ptr   <= ptr_nx;
      end
   end

   // issue register toward the shared unit, plus owner tag pipe aligned to its latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_valid_out   <= 1'b0;
         act_data_out    <= '0;
         act_channel_out <= '0;
         iss_id          <= '0;
         tag_v           <= '0;
         for (int k = 0; k < ACT_LAT; k++) tag_id[k] <= '0;
      end else begin
         act_valid_out   <= hs;
         act_data_out    <= hs ? req_data[gnt*N +: N] : '0;
         act_channel_out <= hs ? req_channel[gnt*CW +: CW] : '0;
         iss_id          <= hs ? gnt : '0;
         tag_v[0]        <= act_valid_out;
         tag_id[0]       <= iss_id;
         for (int k = 1; k < ACT_LAT; k++) begin
            tag_v[k]  <= tag_v[k-1];
            tag_id[k] <= tag_id[k-1];
         end
      end
   end

   // route results to their owner; a valid disagreement drops the beat and latches the error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid   <= '0;
         rsp_data    <= '0;
         rsp_channel <= '0;
         lat_err     <= 1'b0;
      end else begin
         rsp_valid   <= (tail_v && act_valid_in) ? (NUM_REQ'(1) << tail_id) : '0;
         rsp_data    <= (tail_v && act_valid_in) ? act_data_in : '0;
         rsp_channel <= (tail_v && act_valid_in) ? act_channel_in : '0;
         if (tail_v != act_valid_in) lat_err <= 1'b1;
      end
   end

`ifdef ACT_ARB_PERF_CNT_EN
   logic [31:0] perf_cnt [NUM_REQ];

   // accepted-beat counters; clear beats a same-cycle increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_REQ; k++) perf_cnt[k] <= '0;
      end else if (perf_clr) begin
         for (int k = 0; k < NUM_REQ; k++) perf_cnt[k] <= '0;
      end else if (hs) begin
         perf_cnt[gnt] <= perf_cnt[gnt] + 32'd1;
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
      assign perf_beats[g*32 +: 32] = perf_cnt[g];
   end
`endif

endmodule

// File: tb/tb_act_unit_arbiter.sv
`timescale 1ns/1ps
// Directed bench for act_unit_arbiter with a two-cycle ReLU stub as the shared unit.
module tb_act_unit_arbiter;
   localparam int N  = 16;
   localparam int CW = 4;
   localparam int NR = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           enable = 1'b0;
   logic [NR-1:0]  req_valid = '0, req_last = '0;
   logic [NR*N-1:0]  req_data = '0;
   logic [NR*CW-1:0] req_channel = '0;
   logic [NR-1:0]  req_ready;
   logic [N-1:0]   act_data_out, act_data_in, rsp_data;
   logic [CW-1:0]  act_channel_out, act_channel_in, rsp_channel;
   logic           act_valid_out, act_valid_in, busy, lat_err;
   logic [NR-1:0]  rsp_valid;
`ifdef ACT_ARB_PERF_CNT_EN
   logic             perf_clr = 1'b0;
   logic [NR*32-1:0] perf_beats;
`endif

   act_unit_arbiter #(.N(N), .CHANNELS(16), .NUM_REQ(NR), .ACT_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_channel(req_channel), .req_ready(req_ready),
      .act_data_out(act_data_out), .act_channel_out(act_channel_out),
      .act_valid_out(act_valid_out), .act_data_in(act_data_in),
      .act_channel_in(act_channel_in), .act_valid_in(act_valid_in),
      .rsp_data(rsp_data), .rsp_channel(rsp_channel), .rsp_valid(rsp_valid),
      .busy(busy),
`ifdef ACT_ARB_PERF_CNT_EN
      .perf_clr(perf_clr), .perf_beats(perf_beats),
`endif
      .lat_err(lat_err)
   );

   always #5 clk = ~clk;

   // ReLU stub, two cycles deep; inject forces a spurious result valid
   logic          s1_v = 1'b0, s2_v = 1'b0, inject = 1'b0;
   logic [N-1:0]  s1_d = '0, s2_d = '0;
   logic [CW-1:0] s1_c = '0, s2_c = '0;
   always @(posedge clk) begin
      s1_v <= act_valid_out; s1_d <= act_data_out; s1_c <= act_channel_out;
      s2_v <= s1_v;          s2_d <= s1_d;         s2_c <= s1_c;
   end
   assign act_valid_in   = s2_v | inject;
   assign act_data_in    = s2_d[N-1] ? '0 : s2_d;
   assign act_channel_in = s2_c;

   int n_chk = 0, n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // handshake and response logs, sampled mid-cycle
   int            hs_cyc[$], hs_id[$], rsp_cyc[$];
   logic [NR-1:0] rsp_oh[$];
   logic [N-1:0]  rsp_d[$];
   logic [CW-1:0] rsp_c[$];
   always @(negedge clk) begin
      for (int i = 0; i < NR; i++)
         if (req_valid[i] && req_ready[i]) begin
            hs_cyc.push_back(cyc);
            hs_id.push_back(i);
         end
      if (|rsp_valid) begin
         rsp_cyc.push_back(cyc);
         rsp_oh.push_back(rsp_valid);
         rsp_d.push_back(rsp_data);
         rsp_c.push_back(rsp_channel);
      end
   end

   // per-requester beat queues {last, channel, data}; head is presented until accepted
   logic [N+CW:0] q [NR][$];
   initial begin
      logic [NR-1:0] hsq;
      forever begin
         @(negedge clk);
         hsq = req_valid & req_ready;
         @(posedge clk); #1;
         for (int i = 0; i < NR; i++) begin
            if (hsq[i] && q[i].size() > 0) void'(q[i].pop_front());
            if (q[i].size() > 0) begin
               {req_last[i], req_channel[i*CW +: CW], req_data[i*N +: N]} = q[i][0];
               req_valid[i] = 1'b1;
            end else begin
               req_last[i] = 1'b0;
               req_channel[i*CW +: CW] = '0;
               req_data[i*N +: N] = '0;
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   task automatic step(int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic load(int i, logic last, logic [CW-1:0] ch, logic [N-1:0] d);
      q[i].push_back({last, ch, d});
   endtask

   task automatic clear_logs();
      hs_cyc.delete(); hs_id.delete(); rsp_cyc.delete();
      rsp_oh.delete(); rsp_d.delete(); rsp_c.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      inject = 1'b0;
      for (int i = 0; i < NR; i++) q[i].delete();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      step(1);
      clear_logs();
   endtask

   task automatic wait_hs(string tag, int cnt, int budget);
      int t = 0;
      while (hs_cyc.size() < cnt && t < budget) begin step(1); t++; end
      check(tag, 32'(hs_cyc.size()), 32'(cnt));
   endtask

   logic [N-1:0]  t1_in [3] = '{16'h0005, 16'h8001, 16'h7FFF};
   logic [N-1:0]  t1_out[3] = '{16'h0005, 16'h0000, 16'h7FFF};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      do_reset();
      check("rst_ready", 32'(req_ready), 0);
      check("rst_act_v", 32'(act_valid_out), 0);
      check("rst_rsp_v", 32'(rsp_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_lat_err", 32'(lat_err), 0);
      check("rst_ptr", 32'(dut.ptr), 0);

      // single burst from req0 through the ReLU stub
      enable = 1'b1;
      for (int b = 0; b < 3; b++) load(0, b == 2, 4'(b + 1), t1_in[b]);
      wait_hs("t1_hs_cnt", 3, 20);
      step(8);
      for (int b = 0; b < 3; b++) check("t1_hs_id", 32'(hs_id[b]), 0);
      check("t1_hs_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 1);
      check("t1_hs_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 1);
      check("t1_rsp_cnt", 32'(rsp_d.size()), 3);
      if (rsp_d.size() == 3)
         for (int b = 0; b < 3; b++) begin
            check("t1_rsp_oh", 32'(rsp_oh[b]), 32'h1);
            check("t1_rsp_data", 32'(rsp_d[b]), 32'(t1_out[b]));
            check("t1_rsp_ch", 32'(rsp_c[b]), 32'(b + 1));
            check("t1_rsp_lat", 32'(rsp_cyc[b] - hs_cyc[b]), 4);
         end
      check("t1_ptr", 32'(dut.ptr), 1);
      check("t1_ready", 32'(req_ready), 0);
      check("t1_busy", 32'(busy), 0);
`ifdef ACT_ARB_PERF_CNT_EN
      check("t1_perf0", perf_beats[31:0], 3);
`endif

      // contention: all four with 2-beat bursts, from ptr=0
      do_reset();
      for (int i = 0; i < NR; i++)
         for (int b = 0; b < 2; b++) load(i, b == 1, 4'(i * 4 + b), 16'(16'h1000 + i * 16 + b));
      wait_hs("t2_hs_cnt", 8, 40);
      step(8);
      for (int j = 0; j < 8; j++) begin
         check("t2_hs_id", 32'(hs_id[j]), 32'(j / 2));
         if (j > 0) check("t2_hs_gap", 32'(hs_cyc[j] - hs_cyc[j-1]), (j % 2 == 1) ? 1 : 2);
      end
      check("t2_rsp_cnt", 32'(rsp_d.size()), 8);
      if (rsp_d.size() == 8)
         for (int j = 0; j < 8; j++) begin
            check("t2_rsp_oh", 32'(rsp_oh[j]), 32'(1 << (j / 2)));
            check("t2_rsp_data", 32'(rsp_d[j]), 32'(16'h1000 + (j / 2) * 16 + j % 2));
            check("t2_rsp_lat", 32'(rsp_cyc[j] - hs_cyc[j]), 4);
         end

      // fairness: after req1, search from ptr=2 wraps to req0 first
      do_reset();
      load(1, 1'b1, 4'd1, 16'h0111);
      wait_hs("t3_hs_first", 1, 20);
      step(6);
      check("t3_ptr", 32'(dut.ptr), 2);
      clear_logs();
      load(0, 1'b1, 4'd2, 16'h0222);
      load(1, 1'b1, 4'd3, 16'h0333);
      wait_hs("t3_hs_cnt", 2, 30);
      step(6);
      check("t3_first", 32'(hs_id[0]), 0);
      check("t3_second", 32'(hs_id[1]), 1);
      check("t3_rsp_cnt", 32'(rsp_d.size()), 2);
      if (rsp_d.size() == 2) begin
         check("t3_rsp_oh0", 32'(rsp_oh[0]), 32'h1);
         check("t3_rsp_oh1", 32'(rsp_oh[1]), 32'h2);
         check("t3_rsp_d1", 32'(rsp_d[1]), 32'h0333);
      end

      // enable dropped mid-burst of req2: burst completes, no new grant until re-enabled
      do_reset();
      for (int b = 0; b < 4; b++) load(2, b == 3, 4'(b), 16'(16'h0400 + b));
      wait_hs("t4_hs_first", 1, 20);
      enable = 1'b0;
      wait_hs("t4_hs_all", 4, 20);
      for (int b = 0; b < 4; b++) check("t4_hs_id", 32'(hs_id[b]), 2);
      step(2);
      load(0, 1'b1, 4'd5, 16'h0055);
      step(6);
      check("t4_hold_cnt", 32'(hs_cyc.size()), 4);
      check("t4_hold_ready", 32'(req_ready), 0);
      enable = 1'b1;
      wait_hs("t4_resume", 5, 20);
      check("t4_resume_id", 32'(hs_id[4]), 0);
      step(6);

      // spurious result valid with nothing issued
      do_reset();
      step(2);
      inject = 1'b1;
      step(1);
      inject = 1'b0;
      check("t5_lat_err", 32'(lat_err), 1);
      step(5);
      check("t5_sticky", 32'(lat_err), 1);
      check("t5_no_rsp", 32'(rsp_d.size()), 0);
      do_reset();
      check("t5_cleared", 32'(lat_err), 0);

      // async reset between edges after beat 2 of a 5-beat burst
      for (int b = 0; b < 5; b++) load(0, b == 4, 4'(b), 16'(16'h0600 + b));
      wait_hs("t6_hs2", 2, 20);
      check("t6_pre_act_v", 32'(act_valid_out), 1);
      #1 rst_n = 1'b0;
      for (int i = 0; i < NR; i++) q[i].delete();
      #1;
      check("t6_act_v", 32'(act_valid_out), 0);
      check("t6_act_d", 32'(act_data_out), 0);
      check("t6_ready", 32'(req_ready), 0);
      check("t6_rsp_v", 32'(rsp_valid), 0);
      check("t6_busy", 32'(busy), 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      step(2);
      check("t6_post_busy", 32'(busy), 0);
      check("t6_post_ptr", 32'(dut.ptr), 0);
      check("t6_post_ready", 32'(req_ready), 0);
      check("t6_post_lat_err", 32'(lat_err), 0);
`ifdef ACT_ARB_PERF_CNT_EN
      check("t6_perf_rst", perf_beats[31:0], 0);
      clear_logs();
      perf_clr = 1'b1;
      load(0, 1'b1, 4'd7, 16'h0777);
      wait_hs("t6_clr_hs", 1, 20);
      perf_clr = 1'b0;
      step(1);
      check("t6_perf_clr", perf_beats[31:0], 0);
`endif
      step(6);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
